// File: rtl/seg_adder_pkg.sv
// Shared types and helpers for the segmented lane adder.
package seg_adder_pkg;

    localparam int DEFAULT_LANES = 4;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD,
        SAT
    } state_e;

    // A lane opens a fused group when its index is a multiple of the group size.
    function automatic logic is_group_start(input int unsigned lane, input int unsigned fuseLog2);
        int unsigned mask;
        mask = (32'd1 << fuseLog2) - 32'd1;
        return (lane & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/adder_lane.sv
// Combinational WIDTH-bit adder slice; also exposes the carry into the MSB
// so the caller can derive signed overflow.
module adder_lane #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             msb_carry_o
);

    logic [WIDTH-1:0] lowSum;
    logic [1:0]       topSum;

    // Split at the MSB so the carry into the sign bit is visible.
    assign lowSum = {1'b0, a_i[WIDTH-2:0]} + {1'b0, b_i[WIDTH-2:0]}
                  + {{(WIDTH-1){1'b0}}, carry_i};
    assign msb_carry_o = lowSum[WIDTH-1];
    assign topSum = {1'b0, a_i[WIDTH-1]} + {1'b0, b_i[WIDTH-1]} + {1'b0, msb_carry_o};
    assign sum_o = {topSum[0], lowSum[WIDTH-2:0]};
    assign carry_o = topSum[1];

endmodule

// File: rtl/seg_adder_fu.sv
// Run-time fusable LANES x WIDTH add/sub unit, one lane per clock.
// Define SEG_ADDER_SATURATE_EN to add the sat_en port and a signed-clamp SAT state.
module seg_adder_fu
    import seg_adder_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int FW = $clog2(LANES) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]  a,
    input  logic [LANES-1:0][WIDTH-1:0]  b,
    input  logic                         op_sub,
    input  logic [FW-1:0]                fuse_log2,
`ifdef SEG_ADDER_SATURATE_EN
    input  logic                         sat_en,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0][WIDTH-1:0]  sum,
    output logic [LANES-1:0]             lane_carry,
    output logic [LANES-1:0]             overflow
);

    localparam int LW = $clog2(LANES);

    state_e                        state_q, state_d;
    logic                          readyEn_q;
    logic [LW-1:0]                 laneCnt_q, laneCnt_d;
    logic [LANES-1:0][WIDTH-1:0]   aOp_q, aOp_d;
    logic [LANES-1:0][WIDTH-1:0]   bOp_q, bOp_d;
    logic                          opSub_q, opSub_d;
    logic [FW-1:0]                 fuse_q, fuse_d;
    logic                          carry_q, carry_d;
    logic [LANES-1:0][WIDTH-1:0]   sum_q, sum_d;
    logic [LANES-1:0]              laneCarry_q, laneCarry_d;
    logic [LANES-1:0]              overflow_q, overflow_d;

    logic [FW-1:0]    fuseClamped;
    logic [WIDTH-1:0] laneA, laneB, laneSum;
    logic             laneCin, laneCout, laneMsbC;
    logic             groupStart, groupTop;

    assign fuseClamped = (fuse_log2 > FW'(LW)) ? FW'(LW) : fuse_log2;

    assign laneA      = aOp_q[laneCnt_q];
    assign laneB      = opSub_q ? ~bOp_q[laneCnt_q] : bOp_q[laneCnt_q];
    assign groupStart = is_group_start(32'(laneCnt_q), 32'(fuse_q));
    assign groupTop   = is_group_start(32'(laneCnt_q) + 32'd1, 32'(fuse_q));
    assign laneCin    = groupStart ? opSub_q : carry_q;

    adder_lane #(.WIDTH(WIDTH)) u_lane (
        .a_i         (laneA),
        .b_i         (laneB),
        .carry_i     (laneCin),
        .sum_o       (laneSum),
        .carry_o     (laneCout),
        .msb_carry_o (laneMsbC)
    );

`ifdef SEG_ADDER_SATURATE_EN
    logic                        satEn_q, satEn_d;
    logic [LW-1:0]               laneMask;
    logic [LANES-1:0][WIDTH-1:0] satSum;

    assign laneMask = LW'((32'd1 << fuse_q) - 32'd1);

    // Every lane looks up its group's top lane for the overflow flag and the A sign.
    always_comb begin
        satSum = sum_q;
        for (int k = 0; k < LANES; k++) begin
            if (satEn_q && overflow_q[LW'(k) | laneMask]) begin
                if (is_group_start(32'(k + 1), 32'(fuse_q))) begin
                    satSum[k] = {aOp_q[LW'(k) | laneMask][WIDTH-1],
                                 {(WIDTH-1){~aOp_q[LW'(k) | laneMask][WIDTH-1]}}};
                end else begin
                    satSum[k] = {WIDTH{~aOp_q[LW'(k) | laneMask][WIDTH-1]}};
                end
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        laneCnt_d   = laneCnt_q;
        aOp_d       = aOp_q;
        bOp_d       = bOp_q;
        opSub_d     = opSub_q;
        fuse_d      = fuse_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        laneCarry_d = laneCarry_q;
        overflow_d  = overflow_q;
`ifdef SEG_ADDER_SATURATE_EN
        satEn_d     = satEn_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    aOp_d     = a;
                    bOp_d     = b;
                    opSub_d   = op_sub;
                    fuse_d    = fuseClamped;
                    laneCnt_d = '0;
`ifdef SEG_ADDER_SATURATE_EN
                    satEn_d   = sat_en;
`endif
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                sum_d[laneCnt_q]       = laneSum;
                laneCarry_d[laneCnt_q] = laneCout;
                overflow_d[laneCnt_q]  = groupTop & (laneMsbC ^ laneCout);
                carry_d                = laneCout;
                laneCnt_d              = laneCnt_q + 1'b1;
                if (laneCnt_q == LW'(LANES - 1)) begin
`ifdef SEG_ADDER_SATURATE_EN
                    state_d = SAT;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef SEG_ADDER_SATURATE_EN
            SAT: begin
                sum_d   = satSum;
                state_d = HOLD;
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // readyEn_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            readyEn_q   <= 1'b0;
            laneCnt_q   <= '0;
            aOp_q       <= '0;
            bOp_q       <= '0;
            opSub_q     <= 1'b0;
            fuse_q      <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            laneCarry_q <= '0;
            overflow_q  <= '0;
`ifdef SEG_ADDER_SATURATE_EN
            satEn_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            readyEn_q   <= 1'b1;
            laneCnt_q   <= laneCnt_d;
            aOp_q       <= aOp_d;
            bOp_q       <= bOp_d;
            opSub_q     <= opSub_d;
            fuse_q      <= fuse_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            laneCarry_q <= laneCarry_d;
            overflow_q  <= overflow_d;
`ifdef SEG_ADDER_SATURATE_EN
            satEn_q     <= satEn_d;
`endif
        end
    end

    assign in_ready   = readyEn_q && (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign sum        = sum_q;
    assign lane_carry = laneCarry_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg_adder_fu.sv
// Directed self-checking bench for seg_adder_fu (4 x 16-bit build); covers the
// saturating variant as well when SEG_ADDER_SATURATE_EN is defined.
module tb_seg_adder_fu;

    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int FW    = 3;
`ifdef SEG_ADDER_SATURATE_EN
    localparam int LAT = LANES + 1;
`else
    localparam int LAT = LANES;
`endif

    logic                        clk = 1'b0;
    logic                        reset_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES-1:0][WIDTH-1:0] a;
    logic [LANES-1:0][WIDTH-1:0] b;
    logic                        op_sub;
    logic [FW-1:0]               fuse_log2;
    logic                        sat_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES-1:0][WIDTH-1:0] sum;
    logic [LANES-1:0]            lane_carry;
    logic [LANES-1:0]            overflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_adder_fu #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op_sub     (op_sub),
        .fuse_log2  (fuse_log2),
`ifdef SEG_ADDER_SATURATE_EN
        .sat_en     (sat_en),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .lane_carry (lane_carry),
        .overflow   (overflow)
    );

    // One comparison: counts it, and on a miss counts and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set from a negedge and returns 1ns after the accept edge.
    task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv,
                                 input logic sub, input logic [FW-1:0] fuse, input logic sat);
        @(negedge clk);
        a         = av;
        b         = bv;
        op_sub    = sub;
        fuse_log2 = fuse;
        sat_en    = sat;
        in_valid  = 1'b1;
        checkOutput("in_ready before accept", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, bounded.
    task automatic waitResult(input string tag, input int expLat);
        int n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(expLat));
    endtask

    task automatic resultHandshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput({tag, " out_valid drop"}, out_valid, 1'b0);
        checkOutput({tag, " in_ready back"}, in_ready, 1'b1);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        fuse_log2 = '0;
        sat_en    = 1'b0;
        out_ready = 1'b0;

        #2;
        checkOutput("reset in_ready", in_ready, 1'b0);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset sum", sum, 64'h0);
        checkOutput("reset lane_carry", lane_carry, 4'b0000);
        checkOutput("reset overflow", overflow, 4'b0000);
        #10 reset_n = 1'b1;
        #2 checkOutput("in_ready before first edge", in_ready, 1'b0);
        @(posedge clk);
        #1 checkOutput("in_ready after release", in_ready, 1'b1);

        // 4x16 add
        applyStimulus(64'h7FFF_1234_0001_FFFF, 64'h0001_0001_0001_0001, 1'b0, 3'd0, 1'b0);
        waitResult("4x16", LAT);
        checkOutput("4x16 sum", sum, 64'h8000_1235_0002_0000);
        checkOutput("4x16 lane_carry", lane_carry, 4'b0001);
        checkOutput("4x16 overflow", overflow, 4'b1000);
        checkOutput("4x16 in_ready in hold", in_ready, 1'b0);
        resultHandshake("4x16");
        checkOutput("4x16 sum kept in idle", sum, 64'h8000_1235_0002_0000);

        // 1x64 add
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 3'd2, 1'b0);
        waitResult("1x64", LAT);
        checkOutput("1x64 sum", sum, 64'h0000_0001_0000_0000);
        checkOutput("1x64 lane_carry", lane_carry, 4'b0011);
        checkOutput("1x64 overflow", overflow, 4'b0000);
        resultHandshake("1x64");

        // 2x32 subtract: 0-1 in the low group, 5-3 in the high group
        applyStimulus(64'h0000_0005_0000_0000, 64'h0000_0003_0000_0001, 1'b1, 3'd1, 1'b0);
        waitResult("2x32 sub", LAT);
        checkOutput("2x32 sub sum", sum, 64'h0000_0002_FFFF_FFFF);
        checkOutput("2x32 sub lane_carry", lane_carry, 4'b1100);
        checkOutput("2x32 sub overflow", overflow, 4'b0000);
        resultHandshake("2x32 sub");

        // Backpressure with a competing operand set held on the input
        applyStimulus(64'h0003_0002_0001_0000, 64'h0001_0001_0001_0001, 1'b0, 3'd0, 1'b0);
        waitResult("bp first", LAT);
        a         = 64'h1000_2000_3000_4000;
        b         = 64'h0100_0200_0300_0400;
        fuse_log2 = 3'd2;
        op_sub    = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp out_valid held", out_valid, 1'b1);
            checkOutput("bp in_ready low", in_ready, 1'b0);
            checkOutput("bp sum stable", sum, 64'h0004_0003_0002_0001);
        end
        checkOutput("bp lane_carry", lane_carry, 4'b0000);
        checkOutput("bp overflow", overflow, 4'b0000);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput("bp out_valid drop", out_valid, 1'b0);
        checkOutput("bp in_ready back", in_ready, 1'b1);
        checkOutput("bp sum kept", sum, 64'h0004_0003_0002_0001);
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("bp second accepted", in_ready, 1'b0);
        waitResult("bp second", LAT);
        checkOutput("bp second sum", sum, 64'h1100_2200_3300_4400);
        checkOutput("bp second lane_carry", lane_carry, 4'b0000);
        resultHandshake("bp second");

        // Reset while lane 2 is next to be computed
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 3'd2, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid reset sum", sum, 64'h0);
        checkOutput("mid reset lane_carry", lane_carry, 4'b0000);
        checkOutput("mid reset overflow", overflow, 4'b0000);
        checkOutput("mid reset out_valid", out_valid, 1'b0);
        checkOutput("mid reset in_ready", in_ready, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 checkOutput("in_ready while reset low", in_ready, 1'b0);
        reset_n = 1'b1;
        #1 checkOutput("in_ready before edge after release", in_ready, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("in_ready after mid release", in_ready, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("no stale result after reset", out_valid, 1'b0);
        checkOutput("sum still clear after reset", sum, 64'h0);

        // Oversized fuse_log2 clamps to one full-width group
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 3'd7, 1'b0);
        waitResult("clamp", LAT);
        checkOutput("clamp sum", sum, 64'h0000_0001_0000_0000);
        checkOutput("clamp lane_carry", lane_carry, 4'b0011);
        checkOutput("clamp overflow", overflow, 4'b0000);
        resultHandshake("clamp");

`ifdef SEG_ADDER_SATURATE_EN
        applyStimulus(64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 3'd1, 1'b1);
        waitResult("sat on", LANES + 1);
        checkOutput("sat on sum", sum, 64'h0000_0000_7FFF_FFFF);
        checkOutput("sat on overflow", overflow, 4'b0010);
        checkOutput("sat on lane_carry", lane_carry, 4'b0001);
        resultHandshake("sat on");

        applyStimulus(64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 3'd1, 1'b0);
        waitResult("sat off", LANES + 1);
        checkOutput("sat off sum", sum, 64'h0000_0000_8000_0000);
        checkOutput("sat off overflow", overflow, 4'b0010);
        resultHandshake("sat off");
`else
        applyStimulus(64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 3'd1, 1'b0);
        waitResult("wrap", LAT);
        checkOutput("wrap sum", sum, 64'h0000_0000_8000_0000);
        checkOutput("wrap overflow", overflow, 4'b0010);
        checkOutput("wrap lane_carry", lane_carry, 4'b0001);
        resultHandshake("wrap");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
